// File: rtl/ndata_narrower_if.sv
// Stream bundle for ndata_narrower: a wide input stream and a narrow output stream.
//
// Handshake (both sides): a beat transfers on a rising clock edge where valid
// and ready are both high. A source holds data/keep/last stable while valid is
// high and ready is low; valid never waits on ready. A sink may raise or lower
// ready at any time, and ready may depend combinationally on the other side.
interface ndata_narrower_if #(
  parameter type data_t       = logic [31:0],
  parameter int  IN_ELEMENTS  = 8,
  parameter int  OUT_ELEMENTS = 2
);
  localparam int W = $bits(data_t);

  logic [IN_ELEMENTS*W-1:0]  in_data;
  logic [IN_ELEMENTS-1:0]    in_keep;
  logic                      in_last;
  logic                      in_valid;
  logic                      in_ready;

  logic [OUT_ELEMENTS*W-1:0] out_data;
  logic [OUT_ELEMENTS-1:0]   out_keep;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;

  // Converter side: consumes the wide stream, produces the narrow stream.
  modport slave (
    input  in_data, in_keep, in_last, in_valid,
    output in_ready,
    output out_data, out_keep, out_last, out_valid,
    input  out_ready
  );

  // Environment side: produces the wide stream, consumes the narrow stream.
  modport master (
    output in_data, in_keep, in_last, in_valid,
    input  in_ready,
    input  out_data, out_keep, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/ndata_narrower.sv
// ndata_narrower: splits each IN_ELEMENTS-wide beat into OUT_ELEMENTS-wide
// chunks, lowest chunk first, carrying keep through untouched and placing
// last on the final emitted chunk. With SKIP_EMPTY set, chunks whose keep is
// all zero are not emitted; an all-zero beat is dropped unless it carries
// last, in which case it still produces one empty chunk so the packet
// boundary survives.
module ndata_narrower #(
  parameter type data_t       = logic [31:0],
  parameter int  IN_ELEMENTS  = 8,
  parameter int  OUT_ELEMENTS = 2,
  parameter bit  SKIP_EMPTY   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  ndata_narrower_if.slave io
);
  localparam int W     = $bits(data_t);
  localparam int RATIO = IN_ELEMENTS / OUT_ELEMENTS;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IW    = IN_ELEMENTS * W;
  localparam int OW    = OUT_ELEMENTS * W;

  // Holding register for the beat currently being emitted.
  logic [IW-1:0]          r_data;
  logic [IN_ELEMENTS-1:0] r_keep;
  logic                   r_last;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_full;

  logic [RATIO-1:0]        w_held_nz;
  logic [RATIO-1:0]        w_in_nz;
  logic [IDX_W-1:0]        w_final;
  logic [IDX_W-1:0]        w_next_idx;
  logic [IDX_W-1:0]        w_in_first;
  logic                    w_at_final;
  logic                    w_in_ready;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_in_occupies;
  logic [OW-1:0]           w_out_data;
  logic [OUT_ELEMENTS-1:0] w_out_keep;

  // One bit per chunk: does this chunk carry any kept element?
  always_comb begin
    w_held_nz = '0;
    w_in_nz   = '0;
    for (int k = 0; k < RATIO; k++) begin
      w_held_nz[k] = |r_keep[k*OUT_ELEMENTS +: OUT_ELEMENTS];
      w_in_nz[k]   = |io.in_keep[k*OUT_ELEMENTS +: OUT_ELEMENTS];
    end
  end

  // Chunk walk: final chunk of the held beat, next chunk to show, and the
  // starting chunk of an incoming beat. Without skipping every chunk is walked.
  always_comb begin
    w_final    = IDX_W'(RATIO - 1);
    w_in_first = '0;
    w_next_idx = r_idx + IDX_W'(1);
    if (SKIP_EMPTY) begin
      w_final = '0;
      for (int k = 0; k < RATIO; k++) begin
        if (w_held_nz[k]) w_final = IDX_W'(k);
      end
      // Scan downward so the lowest qualifying chunk wins.
      for (int k = RATIO - 1; k >= 0; k--) begin
        if (w_in_nz[k]) w_in_first = IDX_W'(k);
        if (w_held_nz[k] && (IDX_W'(k) > r_idx)) w_next_idx = IDX_W'(k);
      end
    end
  end

  // Select the chunk at r_idx from the holding register.
  always_comb begin
    w_out_data = '0;
    w_out_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_out_data = r_data[k*OW +: OW];
        w_out_keep = r_keep[k*OUT_ELEMENTS +: OUT_ELEMENTS];
      end
    end
  end

  assign w_at_final = (r_idx == w_final);
  // Accept a new beat when empty, or when the last chunk leaves this cycle.
  assign w_in_ready = rst_n && (!r_full || (w_at_final && io.out_ready));
  assign w_in_fire  = io.in_valid && w_in_ready;
  assign w_out_fire = r_full && io.out_ready;
  // An all-empty, non-last beat has nothing to say and is dropped.
  assign w_in_occupies = !SKIP_EMPTY || (|io.in_keep) || io.in_last;

  // Holding register: load on input handshake, otherwise step or free on output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (w_in_fire) begin
      r_data <= io.in_data;
      r_keep <= io.in_keep;
      r_last <= io.in_last;
      r_idx  <= w_in_first;
      r_full <= w_in_occupies;
    end else if (w_out_fire) begin
      if (!w_at_final) begin
        r_idx <= w_next_idx;
      end else begin
        r_full <= 1'b0;
      end
    end
  end

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = r_full;
  assign io.out_last  = r_full && r_last && w_at_final;
  assign io.out_data  = w_out_data;
  assign io.out_keep  = w_out_keep;

endmodule

// File: tb/tb_ndata_narrower.sv
// Bench for ndata_narrower: two instances (SKIP_EMPTY=0 and =1) share one
// stimulus stream; each has its own list-based reference model and scoreboard.
module tb_ndata_narrower;
  localparam int W     = 32;
  localparam int IN    = 8;
  localparam int OUT   = 2;
  localparam int RATIO = IN / OUT;
  localparam int IW    = IN * W;
  localparam int OW    = OUT * W;
  localparam int CW    = OW + OUT + 1;

  logic clk = 1'b0;
  logic rst_n;
  bit   rdy_rand = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fires0  = 0;
  int   fires1  = 0;

  logic [CW-1:0] exp0_q[$];
  logic [CW-1:0] exp1_q[$];

  ndata_narrower_if #(.data_t(logic [31:0]), .IN_ELEMENTS(IN), .OUT_ELEMENTS(OUT)) if0 ();
  ndata_narrower_if #(.data_t(logic [31:0]), .IN_ELEMENTS(IN), .OUT_ELEMENTS(OUT)) if1 ();

  ndata_narrower #(.data_t(logic [31:0]), .IN_ELEMENTS(IN), .OUT_ELEMENTS(OUT), .SKIP_EMPTY(1'b0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .io(if0));
  ndata_narrower #(.data_t(logic [31:0]), .IN_ELEMENTS(IN), .OUT_ELEMENTS(OUT), .SKIP_EMPTY(1'b1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .io(if1));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: list the chunks a beat must produce, then queue them.
  task automatic push_model(input bit skip, input logic [IW-1:0] d, input logic [IN-1:0] k,
                            input logic l);
    int emit[$];
    logic [CW-1:0] item;
    for (int c = 0; c < RATIO; c++) begin
      if (!skip || (k[c*OUT +: OUT] != '0)) emit.push_back(c);
    end
    if (emit.size() == 0 && l) emit.push_back(0);
    for (int i = 0; i < emit.size(); i++) begin
      item = {d[emit[i]*OW +: OW], k[emit[i]*OUT +: OUT], l && (i == emit.size() - 1)};
      if (skip) exp1_q.push_back(item);
      else      exp0_q.push_back(item);
    end
  endtask

  // ---------------- output sinks ----------------
  always @(posedge clk) begin
    #1;
    if0.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if1.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- scoreboards ----------------
  logic [CW-1:0] prev0, prev1, got0, got1, exp0, exp1;
  bit stall0 = 1'b0, stall1 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall0 = 1'b0;
    end else begin
      got0 = {if0.out_data, if0.out_keep, if0.out_last};
      if (stall0) begin
        check("stall0_valid", if0.out_valid, 1'b1);
        check("stall0_hold", got0, prev0);
      end
      if (if0.out_valid && if0.out_ready) begin
        fires0++;
        check("q0_nonempty", exp0_q.size() > 0, 1'b1);
        if (exp0_q.size() > 0) begin
          exp0 = exp0_q.pop_front();
          check("chunk0", got0, exp0);
        end
      end
      stall0 = if0.out_valid && !if0.out_ready;
      prev0  = got0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall1 = 1'b0;
    end else begin
      got1 = {if1.out_data, if1.out_keep, if1.out_last};
      if (stall1) begin
        check("stall1_valid", if1.out_valid, 1'b1);
        check("stall1_hold", got1, prev1);
      end
      if (if1.out_valid && if1.out_ready) begin
        fires1++;
        check("q1_nonempty", exp1_q.size() > 0, 1'b1);
        if (exp1_q.size() > 0) begin
          exp1 = exp1_q.pop_front();
          check("chunk1", got1, exp1);
        end
      end
      stall1 = if1.out_valid && !if1.out_ready;
      prev1  = got1;
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers are entered and left just after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [IW-1:0] d, input logic [IN-1:0] k, input logic l);
    if0.in_data = d; if0.in_keep = k; if0.in_last = l;
    if1.in_data = d; if1.in_keep = k; if1.in_last = l;
  endtask

  task automatic send_beat(input logic [IW-1:0] d, input logic [IN-1:0] k, input logic l);
    bit done0 = 1'b0;
    bit done1 = 1'b0;
    int budget = 0;
    set_beat(d, k, l);
    if0.in_valid = 1'b1;
    if1.in_valid = 1'b1;
    while (!(done0 && done1) && budget < 200) begin
      @(negedge clk);
      if (!done0 && if0.in_valid && if0.in_ready) begin push_model(1'b0, d, k, l); done0 = 1'b1; end
      if (!done1 && if1.in_valid && if1.in_ready) begin push_model(1'b1, d, k, l); done1 = 1'b1; end
      step();
      if (done0) if0.in_valid = 1'b0;
      if (done1) if1.in_valid = 1'b0;
      budget++;
    end
    check("accept0", done0, 1'b1);
    check("accept1", done1, 1'b1);
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0 || if0.out_valid || if1.out_valid)
           && budget < 1000) begin
      step();
      budget++;
    end
    check("idle_q0", exp0_q.size(), 0);
    check("idle_q1", exp1_q.size(), 0);
  endtask

  task automatic ready_always();
    rdy_rand = 1'b0;
    repeat (2) step();
  endtask

  function automatic logic [IW-1:0] ramp_data(input int base);
    logic [IW-1:0] d;
    for (int i = 0; i < IN; i++) d[i*W +: W] = W'(base + i);
    return d;
  endfunction

  // ---------------- directed tests ----------------
  task automatic stream_test();
    logic [IW-1:0] d;
    d = ramp_data(0);
    ready_always();
    wait_idle();
    set_beat(d, 8'hFF, 1'b1);
    if0.in_valid = 1'b1;
    if1.in_valid = 1'b1;
    @(negedge clk);
    check("st_rdy0", if0.in_ready, 1'b1);
    check("st_rdy1", if1.in_ready, 1'b1);
    push_model(1'b0, d, 8'hFF, 1'b1);
    push_model(1'b1, d, 8'hFF, 1'b1);
    step();
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("st_valid0", if0.out_valid, 1'b1);
      check("st_inrdy0", if0.in_ready, c == 4);
      check("st_last0", if0.out_last, c == 4);
      check("st_last1", if1.out_last, c == 4);
    end
    @(negedge clk);
    check("st_done0", if0.out_valid, 1'b0);
    step();
  endtask

  task automatic fire_test(input string tag, input logic [IN-1:0] k, input logic l,
                           input int exp_d0, input int exp_d1);
    int f0, f1;
    ready_always();
    wait_idle();
    f0 = fires0;
    f1 = fires1;
    send_beat(ramp_data(16), k, l);
    wait_idle();
    check({tag, "_n0"}, fires0 - f0, exp_d0);
    check({tag, "_n1"}, fires1 - f1, exp_d1);
  endtask

  task automatic b2b_test();
    logic [IW-1:0] da, db;
    da = ramp_data(32);
    db = ramp_data(64);
    ready_always();
    wait_idle();
    if0.in_data = da; if0.in_keep = 8'hFF; if0.in_last = 1'b0;
    if0.in_valid = 1'b1;
    @(negedge clk);
    check("b2b_rdyA", if0.in_ready, 1'b1);
    push_model(1'b0, da, 8'hFF, 1'b0);
    step();
    if0.in_data = db; if0.in_keep = 8'hFF; if0.in_last = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("b2b_valid", if0.out_valid, 1'b1);
      if (c <= 4) check("b2b_inrdy", if0.in_ready, c == 4);
      if (c == 4) begin
        if (if0.in_ready) push_model(1'b0, db, 8'hFF, 1'b1);
        step();
        if0.in_valid = 1'b0;
      end
    end
    wait_idle();
  endtask

  task automatic reset_test();
    logic [IW-1:0] d;
    d = ramp_data(96);
    ready_always();
    wait_idle();
    set_beat(d, 8'hFF, 1'b1);
    if0.in_valid = 1'b1;
    if1.in_valid = 1'b1;
    @(negedge clk);
    push_model(1'b0, d, 8'hFF, 1'b1);
    push_model(1'b1, d, 8'hFF, 1'b1);
    step();
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    #1;
    check("rst_valid0", if0.out_valid, 1'b0);
    check("rst_valid1", if1.out_valid, 1'b0);
    check("rst_inrdy0", if0.in_ready, 1'b0);
    check("rst_last0", if0.out_last, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_inrdy0", if0.in_ready, 1'b1);
    check("rel_inrdy1", if1.in_ready, 1'b1);
    check("rel_valid0", if0.out_valid, 1'b0);
    step();
    send_beat(ramp_data(128), 8'hFF, 1'b1);
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [IW-1:0] d;
    logic [IN-1:0] k;
    logic [IN-1:0] m;
    logic l;
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    set_beat('0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid0", if0.out_valid, 1'b0);
    check("reset_valid1", if1.out_valid, 1'b0);
    check("reset_inrdy0", if0.in_ready, 1'b0);
    check("reset_last1", if1.out_last, 1'b0);
    check("reset_data0", {if0.out_data, if0.out_keep}, '0);
    rst_n = 1'b1;
    #1;
    check("first_inrdy0", if0.in_ready, 1'b1);
    check("first_inrdy1", if1.in_ready, 1'b1);
    step();

    stream_test();
    fire_test("skip30", 8'h30, 1'b1, 4, 1);
    fire_test("empty_nolast", 8'h00, 1'b0, 4, 0);
    fire_test("empty_last", 8'h00, 1'b1, 4, 1);
    fire_test("hi_only", 8'hC0, 1'b0, 4, 1);
    b2b_test();
    reset_test();

    // Randomized traffic under 50% output backpressure.
    rdy_rand = 1'b1;
    for (int b = 0; b < 100; b++) begin
      for (int i = 0; i < IN; i++) d[i*W +: W] = $urandom;
      case ($urandom_range(0, 3))
        0: k = 8'hFF;
        1: k = 8'h00;
        2: k = IN'($urandom);
        default: begin
          for (int c = 0; c < RATIO; c++) m[c*OUT +: OUT] = $urandom_range(0, 1) ? 2'b11 : 2'b00;
          k = IN'($urandom) & m;
        end
      endcase
      l = ($urandom_range(0, 3) == 0);
      send_beat(d, k, l);
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
